// File: rtl/hms_timekeeper.sv
// Cascaded hours:minutes:seconds timekeeper with a built-in prescaler,
// up/down counting, range-checked atomic load and per-field wrap pulses.
module hms_timekeeper #(
  parameter int TICK_DIV  = 1,
  parameter int HOURS_MOD = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       count_down,
  input  logic       load,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       min_rollover,
  output logic       hour_rollover,
  output logic       day_rollover,
  output logic       load_err
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [4:0]    HOUR_LAST = 5'(HOURS_MOD - 1);

  logic [PW-1:0] pre_r;
  logic          tick_s;
  logic          load_ok_s;
  logic          sec_wrap_s;
  logic          min_wrap_s;
  logic          hour_wrap_s;
  logic [4:0]    hours_nxt_s;
  logic [5:0]    minutes_nxt_s;
  logic [5:0]    seconds_nxt_s;

  // Tick decode and load range check
  always_comb begin
    tick_s    = enable && (pre_r == PRE_LAST);
    load_ok_s = (load_ss <= 6'd59) && (load_mm <= 6'd59) && (load_hh <= HOUR_LAST);
  end

  // Next field values for one tick; each field moves only when the lower one wraps
  always_comb begin
    sec_wrap_s    = 1'b0;
    min_wrap_s    = 1'b0;
    hour_wrap_s   = 1'b0;
    hours_nxt_s   = hours;
    minutes_nxt_s = minutes;
    seconds_nxt_s = seconds;
    if (count_down) begin
      sec_wrap_s    = (seconds == 6'd0);
      min_wrap_s    = sec_wrap_s && (minutes == 6'd0);
      hour_wrap_s   = min_wrap_s && (hours == 5'd0);
      seconds_nxt_s = sec_wrap_s ? 6'd59 : (seconds - 6'd1);
      if (sec_wrap_s) begin
        minutes_nxt_s = min_wrap_s ? 6'd59 : (minutes - 6'd1);
      end else begin
        minutes_nxt_s = minutes;
      end
      if (min_wrap_s) begin
        hours_nxt_s = hour_wrap_s ? HOUR_LAST : (hours - 5'd1);
      end else begin
        hours_nxt_s = hours;
      end
    end else begin
      sec_wrap_s    = (seconds == 6'd59);
      min_wrap_s    = sec_wrap_s && (minutes == 6'd59);
      hour_wrap_s   = min_wrap_s && (hours == HOUR_LAST);
      seconds_nxt_s = sec_wrap_s ? 6'd0 : (seconds + 6'd1);
      if (sec_wrap_s) begin
        minutes_nxt_s = min_wrap_s ? 6'd0 : (minutes + 6'd1);
      end else begin
        minutes_nxt_s = minutes;
      end
      if (min_wrap_s) begin
        hours_nxt_s = hour_wrap_s ? 5'd0 : (hours + 5'd1);
      end else begin
        hours_nxt_s = hours;
      end
    end
  end

  // State and pulse registers: reset > load > tick > prescale > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r         <= '0;
      hours         <= 5'd0;
      minutes       <= 6'd0;
      seconds       <= 6'd0;
      sec_tick      <= 1'b0;
      min_rollover  <= 1'b0;
      hour_rollover <= 1'b0;
      day_rollover  <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      sec_tick      <= 1'b0;
      min_rollover  <= 1'b0;
      hour_rollover <= 1'b0;
      day_rollover  <= 1'b0;
      load_err      <= 1'b0;
      if (load) begin
        // A rejected load still restarts the second period
        pre_r <= '0;
        if (load_ok_s) begin
          hours   <= load_hh;
          minutes <= load_mm;
          seconds <= load_ss;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick_s) begin
        pre_r         <= '0;
        hours         <= hours_nxt_s;
        minutes       <= minutes_nxt_s;
        seconds       <= seconds_nxt_s;
        sec_tick      <= 1'b1;
        min_rollover  <= sec_wrap_s;
        hour_rollover <= min_wrap_s;
        day_rollover  <= hour_wrap_s;
      end else if (enable) begin
        pre_r <= pre_r + PW'(1);
      end else begin
        pre_r <= pre_r;
      end
    end
  end

endmodule
